// File: rtl/mac_pkg.sv
// Shared MAC definitions: FloPoCo exception codes, canonical NaN and the y_writer state enum.
package mac_pkg;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [63:0] IEEE_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } y_state_t;

endpackage

// File: rtl/flopoco_to_ieee.sv
// Combinational FloPoCo (wE=11, wF=52, 2-bit exception) to IEEE-754 double conversion.
module flopoco_to_ieee
  import mac_pkg::*;
(
  input  logic [65:0] v,
  output logic [63:0] d
);

  always_comb begin
    d = IEEE_QNAN;
    case (v[65:64])
      EXC_ZERO:   d = {v[63], 63'b0};
      // Exponent bias of wE=11 matches IEEE, so normals pass straight through.
      EXC_NORMAL: d = v[63:0];
      EXC_INF:    d = {v[63], 11'h7FF, 52'b0};
      EXC_NAN:    d = IEEE_QNAN;
      default:    d = IEEE_QNAN;
    endcase
  end

endmodule

// File: rtl/std_fifo.sv
// Synchronous single-clock FIFO; the head word is visible on rd_data whenever empty is low.
module std_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/y_writer.sv
// Buffers finished rows from the intermediator and writes them to y[] as IEEE doubles.
// Optional sticky error reporting is enabled by defining Y_WRITER_ERR_EN.
module y_writer
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              push,
  input  logic [65:0]       v,
  input  logic              eof,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_data,
  input  logic              mem_stall,
  output logic [31:0]       rows_written,
  output logic              done,
  output logic              err,
  output y_state_t          state_dbg
);

  // Memory handshake: mem_req is valid, !mem_stall is ready; a request transfers on a
  // cycle where both hold, and mem_req/mem_addr/mem_data are frozen until it does.

  y_state_t    state_q;
  y_state_t    state_d;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_wr;
  logic [65:0] fifo_head;
  logic [63:0] head_ieee;
  logic        accept;
  logic        load;

  assign accept    = mem_req && !mem_stall;
  assign load      = !fifo_empty && (!mem_req || accept);
  assign fifo_wr   = push && (state_q != IDLE) && !fifo_full;
  assign state_dbg = state_q;

  std_fifo #(
    .WIDTH (66),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (v),
    .rd_en   (load),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  flopoco_to_ieee u_conv (
    .v (fifo_head),
    .d (head_ieee)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (eof) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Completion only once both the buffer and the output register are empty.
        if (fifo_empty && !mem_req) begin
          state_d = IDLE;
          done    = !rst;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      rows_written <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        mem_addr     <= base_addr;
        rows_written <= '0;
      end else if (accept) begin
        mem_addr     <= mem_addr + ADDR_W'(8);
        rows_written <= rows_written + 32'd1;
      end
      if (load) begin
        mem_req  <= 1'b1;
        mem_data <= head_ieee;
      end else if (accept) begin
        mem_req <= 1'b0;
      end
    end
  end

`ifdef Y_WRITER_ERR_EN
  logic err_q;
  logic drop;
  logic bad_start;

  assign drop      = push && ((state_q == IDLE) || fifo_full);
  assign bad_start = start && (state_q != IDLE);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (drop || bad_start) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_y_writer.sv
// Directed self-checking bench for y_writer: normal job, exception mapping, stall, overflow,
// empty job, reset mid-drain, dropped IDLE push and start-while-busy.
module tb_y_writer;
  import mac_pkg::*;

`ifdef Y_WRITER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] base_addr = '0;
  logic        push = 1'b0;
  logic [65:0] v = '0;
  logic        eof = 1'b0;
  logic        mem_req;
  logic [47:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_stall = 1'b0;
  logic [31:0] rows_written;
  logic        done;
  logic        err;
  y_state_t    state_dbg;

  always #5 clk = ~clk;

  y_writer #(
    .FIFO_DEPTH (64),
    .ADDR_W     (48)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .push         (push),
    .v            (v),
    .eof          (eof),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_stall    (mem_stall),
    .rows_written (rows_written),
    .done         (done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // ---------------- monitor (records accepted writes, req cycles, done pulses) ----------------
  logic [111:0] obs_mem [512];
  int           obs_n    = 0;
  int           req_cnt  = 0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && mem_req) req_cnt <= req_cnt + 1;
    if (!rst && done) done_cnt <= done_cnt + 1;
    if (!rst && mem_req && !mem_stall && obs_n < 512) begin
      obs_mem[obs_n] <= {mem_addr, mem_data};
      obs_n          <= obs_n + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [111:0] exp_q[$];
  int           obs_rd   = 0;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_drained(input string tag);
    logic [111:0] e;
    chk({tag, "_count"}, obs_n - obs_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_n) begin
        chk(tag, obs_mem[obs_rd], e);
        obs_rd++;
      end
    end
    obs_rd = obs_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [65:0] val, input logic [47:0] ea, input logic [63:0] ed,
                           input bit keep);
    push = 1'b1;
    v    = val;
    if (keep) exp_q.push_back({ea, ed});
    tick();
  endtask

  task automatic start_job(input logic [47:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rc;
    int dc;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 48'h0);
    chk("rst_data", mem_data, 64'h0);
    chk("rst_rows", rows_written, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    tick();

    // Job 1: three normals, latency N+2, done one cycle after the last accept
    start_job(48'h1000);
    chk("j1_state", state_dbg, RUN);
    push_beat(66'h1_3FF0_0000_0000_0000, 48'h1000, 64'h3FF0_0000_0000_0000, 1);
    chk("j1_lat_n1", mem_req, 1'b0);
    push_beat(66'h1_4000_0000_0000_0000, 48'h1008, 64'h4000_0000_0000_0000, 1);
    chk("j1_lat_n2", mem_req, 1'b1);
    chk("j1_addr0", mem_addr, 48'h1000);
    chk("j1_data0", mem_data, 64'h3FF0_0000_0000_0000);
    push_beat(66'h1_C008_0000_0000_0000, 48'h1010, 64'hC008_0000_0000_0000, 1);
    chk("j1_addr1", mem_addr, 48'h1008);
    push = 1'b0;
    eof  = 1'b1;
    tick();
    eof = 1'b0;
    chk("j1_addr2", mem_addr, 48'h1010);
    chk("j1_done_early", done, 1'b0);
    tick();
    chk("j1_done", done, 1'b1);
    chk("j1_req_off", mem_req, 1'b0);
    chk("j1_rows", rows_written, 32'd3);
    chk("j1_state_drain", state_dbg, DRAIN);
    tick();
    chk("j1_done_once", done, 1'b0);
    chk("j1_state_idle", state_dbg, IDLE);
    check_drained("j1_wr");

    // Job 2: exception mapping
    start_job(48'h2000);
    push_beat(66'h0_8123_4567_89AB_CDEF, 48'h2000, 64'h8000_0000_0000_0000, 1);
    push_beat(66'h2_1234_5678_9ABC_DEF0, 48'h2008, 64'h7FF0_0000_0000_0000, 1);
    push_beat(66'h3_FFFF_0000_1111_2222, 48'h2010, 64'h7FF8_0000_0000_0000, 1);
    push_beat(66'h0_7FF0_0000_0000_0001, 48'h2018, 64'h0000_0000_0000_0000, 1);
    push = 1'b0;
    eof  = 1'b1;
    tick();
    eof = 1'b0;
    wait_done(50, "j2_done");
    chk("j2_rows", rows_written, 32'd4);
    tick();
    check_drained("j2_wr");
    chk("j2_err", err, 1'b0);

    // Job 3: 10-cycle stall across 5 back-to-back pushes
    start_job(48'h3000);
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_beat({2'b01, 64'h4010_0000_0000_0000 + 64'(i)}, 48'h3000 + 48'(8 * i),
                64'h4010_0000_0000_0000 + 64'(i), 1);
    end
    push = 1'b0;
    chk("j3_req", mem_req, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j3_hold_req", mem_req, 1'b1);
      chk("j3_hold_addr", mem_addr, 48'h3000);
      chk("j3_hold_data", mem_data, 64'h4010_0000_0000_0000);
    end
    mem_stall = 1'b0;
    tick();
    chk("j3_next_addr", mem_addr, 48'h3008);
    chk("j3_next_data", mem_data, 64'h4010_0000_0000_0001);
    chk("j3_next_req", mem_req, 1'b1);
    eof = 1'b1;
    tick();
    eof = 1'b0;
    wait_done(50, "j3_done");
    chk("j3_rows", rows_written, 32'd5);
    tick();
    check_drained("j3_wr");

    // Job 4: overflow under stall, FIFO_DEPTH+1 retained
    start_job(48'h4000);
    mem_stall = 1'b1;
    for (int i = 0; i < 67; i++) begin
      push_beat({2'b01, 64'h3FE0_0000_0000_0000 + 64'(i)}, 48'h4000 + 48'(8 * i),
                64'h3FE0_0000_0000_0000 + 64'(i), i < 65);
    end
    push = 1'b0;
    chk("j4_err", err, ERR_EN);
    chk("j4_addr_held", mem_addr, 48'h4000);
    chk("j4_rows_held", rows_written, 32'd0);
    mem_stall = 1'b0;
    eof = 1'b1;
    tick();
    eof = 1'b0;
    wait_done(200, "j4_done");
    chk("j4_rows", rows_written, 32'd65);
    tick();
    check_drained("j4_wr");

    // Job 5: empty job
    rc = req_cnt;
    start_job(48'h5000);
    eof = 1'b1;
    chk("j5_done_pre", done, 1'b0);
    tick();
    eof = 1'b0;
    chk("j5_done", done, 1'b1);
    chk("j5_rows", rows_written, 32'd0);
    tick();
    chk("j5_done_once", done, 1'b0);
    chk("j5_state", state_dbg, IDLE);
    chk("j5_no_req", req_cnt, rc);

    // Job 6: reset mid-DRAIN with 4 entries pending
    start_job(48'h6000);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_beat({2'b01, 64'h4020_0000_0000_0000 + 64'(i)}, 48'h0, 64'h0, 0);
    end
    push = 1'b0;
    eof  = 1'b1;
    tick();
    eof = 1'b0;
    chk("j6_state_drain", state_dbg, DRAIN);
    dc  = done_cnt;
    rst = 1'b1;
    tick();
    chk("j6_req", mem_req, 1'b0);
    chk("j6_rows", rows_written, 32'd0);
    chk("j6_data", mem_data, 64'h0);
    chk("j6_state", state_dbg, IDLE);
    chk("j6_err", err, 1'b0);
    rst       = 1'b0;
    mem_stall = 1'b0;
    rc        = req_cnt;
    repeat (10) tick();
    chk("j6_no_done", done_cnt, dc);
    chk("j6_no_req", req_cnt, rc);
    check_drained("j6_wr");

    // Job 7: push in IDLE is dropped; start while busy is ignored
    rc = req_cnt;
    push_beat(66'h1_4030_0000_0000_0000, 48'h0, 64'h0, 0);
    push = 1'b0;
    repeat (4) tick();
    chk("j7_idle_drop", req_cnt, rc);
    chk("j7_idle_err", err, ERR_EN);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("j7_err_clr", err, 1'b0);
    start_job(48'h7000);
    start_job(48'h9000);
    chk("j7_busy_err", err, ERR_EN);
    push_beat(66'h1_4040_0000_0000_0000, 48'h7000, 64'h4040_0000_0000_0000, 1);
    push = 1'b0;
    eof  = 1'b1;
    tick();
    eof = 1'b0;
    wait_done(50, "j7_done");
    chk("j7_rows", rows_written, 32'd1);
    tick();
    check_drained("j7_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
